// File: rtl/counter_pkg.sv
// Shared types for the modulo-k down-counter.
// FSM state encoding used by counter_mod_k_down.
package counter_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } counter_state_t;

endpackage

// File: rtl/counter_mod_k_down.sv
// Loadable modulo-k down-counter with one-shot and periodic modes.
// Emits a registered one-cycle borrow pulse when an enabled tick passes zero.
module counter_mod_k_down
  import counter_pkg::*;
#(
  parameter int N = 3
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic [N-1:0] i_k,
  input  logic         i_en,
  input  logic         i_start,
  input  logic         i_stop,
  input  logic         i_periodic,
  output logic [N-1:0] o_count,
  output logic         o_borrow,
  output logic         o_busy
);

  localparam logic [N-1:0] ONE = N'(1);

  counter_state_t state;
  logic [N-1:0]   count;
  logic [N-1:0]   k_q;
  logic           periodic_q;
  logic           borrow;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state      <= ST_IDLE;
      count      <= '0;
      borrow     <= 1'b0;
      k_q        <= '0;
      periodic_q <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          borrow <= 1'b0;
          if (i_start && !i_stop && (i_k != '0)) begin
            k_q        <= i_k;
            periodic_q <= i_periodic;
            count      <= i_k - ONE;
            state      <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (i_stop) begin
            state  <= ST_IDLE;
            count  <= '0;
            borrow <= 1'b0;
          end else if (i_en) begin
            if (count == '0) begin
              // Reload in the same edge so the period has no gap cycle.
              borrow <= 1'b1;
              if (periodic_q) begin
                count <= k_q - ONE;
              end else begin
                count <= '0;
                state <= ST_IDLE;
              end
            end else begin
              count  <= count - ONE;
              borrow <= 1'b0;
            end
          end else begin
            borrow <= 1'b0;
          end
        end
        default: begin
          state  <= ST_IDLE;
          count  <= '0;
          borrow <= 1'b0;
        end
      endcase
    end
  end

  assign o_count  = count;
  assign o_borrow = borrow;
  assign o_busy   = (state == ST_RUN);

endmodule

// File: tb/tb_counter_mod_k_down.sv
// Randomized self-checking bench for counter_mod_k_down.
// Reference model counts enabled ticks since start and derives count by modulo.
module tb_counter_mod_k_down;

  localparam int N = 3;

  logic         i_clk = 1'b0;
  logic         i_reset = 1'b0;
  logic [N-1:0] i_k = '0;
  logic         i_en = 1'b0;
  logic         i_start = 1'b0;
  logic         i_stop = 1'b0;
  logic         i_periodic = 1'b0;
  logic [N-1:0] o_count;
  logic         o_borrow;
  logic         o_busy;

  int checks = 0;
  int failures = 0;

  // model: active flag, latched k/mode, enabled ticks since start, borrow
  bit m_active;
  int m_k;
  bit m_per;
  int m_ticks;
  bit m_borrow;

  counter_mod_k_down #(.N(N)) dut (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_k       (i_k),
    .i_en      (i_en),
    .i_start   (i_start),
    .i_stop    (i_stop),
    .i_periodic(i_periodic),
    .o_count   (o_count),
    .o_borrow  (o_borrow),
    .o_busy    (o_busy)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [N+1:0] exp_vec();
    int c;
    c = m_active ? (m_k - 1 - (m_ticks % m_k)) : 0;
    return {c[N-1:0], m_borrow, m_active};
  endfunction

  function automatic logic [N+1:0] got_vec();
    return {o_count, o_borrow, o_busy};
  endfunction

  task automatic model_reset();
    m_active = 0;
    m_k = 1;
    m_per = 0;
    m_ticks = 0;
    m_borrow = 0;
  endtask

  task automatic step(input logic s, input logic st, input logic e,
                      input logic [N-1:0] k, input logic p);
    i_start = s;
    i_stop = st;
    i_en = e;
    i_k = k;
    i_periodic = p;
    @(posedge i_clk);
    if (!m_active) begin
      m_borrow = 0;
      if (s && !st && k != 0) begin
        m_active = 1;
        m_k = int'(k);
        m_per = p;
        m_ticks = 0;
      end
    end else if (st) begin
      m_active = 0;
      m_borrow = 0;
    end else if (e) begin
      m_ticks++;
      m_borrow = (m_ticks % m_k) == 0;
      if (m_borrow && !m_per) m_active = 0;
    end else begin
      m_borrow = 0;
    end
    @(negedge i_clk);
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_start = 0;
    i_stop = 0;
    i_en = 0;
    i_reset = 1'b1;
    model_reset();
    @(negedge i_clk);
    i_reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (got_vec() !== 5'b000_0_0) begin
      failures++;
      $display("FAIL reset got=%b exp=%b", got_vec(), 5'b000_0_0);
    end
  endtask

  task automatic test_periodic();
    do_reset();
    step(1, 0, 1, 3'd4, 1);
    for (int i = 0; i < 13; i++) begin
      checks++;
      if (got_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL periodic cyc=%0d got=%b exp=%b", i, got_vec(), exp_vec());
      end
      step(0, 0, 1, 3'd4, 1);
    end
  endtask

  task automatic test_one_shot();
    do_reset();
    step(1, 0, 1, 3'd4, 0);
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (got_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL one_shot cyc=%0d got=%b exp=%b", i, got_vec(), exp_vec());
      end
      step(0, 0, 1, 3'd4, 0);
    end
    step(1, 0, 1, 3'd4, 0);
    checks++;
    if (got_vec() !== 5'b011_0_1) begin
      failures++;
      $display("FAIL one_shot_restart got=%b exp=%b", got_vec(), 5'b011_0_1);
    end
  endtask

  task automatic test_en_toggle();
    do_reset();
    step(1, 0, 0, 3'd5, 1);
    for (int i = 0; i < 12; i++) begin
      step(0, 0, (i % 2) == 0, 3'd5, 1);
      checks++;
      if (got_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL en_toggle cyc=%0d got=%b exp=%b", i, got_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_stop();
    do_reset();
    step(1, 0, 0, 3'd3, 1);
    step(0, 0, 1, 3'd3, 1);
    step(0, 0, 1, 3'd3, 1);
    checks++;
    if (got_vec() !== 5'b000_0_1) begin
      failures++;
      $display("FAIL stop_pre got=%b exp=%b", got_vec(), 5'b000_0_1);
    end
    step(0, 1, 1, 3'd3, 1);
    checks++;
    if (got_vec() !== 5'b000_0_0) begin
      failures++;
      $display("FAIL stop_at_zero got=%b exp=%b", got_vec(), 5'b000_0_0);
    end
    step(1, 1, 1, 3'd3, 1);
    checks++;
    if (got_vec() !== 5'b000_0_0) begin
      failures++;
      $display("FAIL start_stop_idle got=%b exp=%b", got_vec(), 5'b000_0_0);
    end
  endtask

  task automatic test_k_bounds();
    do_reset();
    step(1, 0, 1, 3'd0, 1);
    checks++;
    if (got_vec() !== 5'b000_0_0) begin
      failures++;
      $display("FAIL k_zero got=%b exp=%b", got_vec(), 5'b000_0_0);
    end
    step(1, 0, 1, 3'd1, 1);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1, 3'd1, 1);
      checks++;
      if (got_vec() !== 5'b000_1_1) begin
        failures++;
        $display("FAIL k_one cyc=%0d got=%b exp=%b", i, got_vec(), 5'b000_1_1);
      end
    end
    do_reset();
    step(1, 0, 1, 3'd7, 1);
    for (int i = 0; i < 15; i++) begin
      checks++;
      if (got_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL k_max cyc=%0d got=%b exp=%b", i, got_vec(), exp_vec());
      end
      step(0, 0, 1, 3'd7, 1);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(1, 0, 1, 3'd4, 1);
    step(0, 0, 1, 3'd4, 1);
    checks++;
    if (got_vec() !== 5'b010_0_1) begin
      failures++;
      $display("FAIL async_pre got=%b exp=%b", got_vec(), 5'b010_0_1);
    end
    #2;
    i_reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if (got_vec() !== 5'b000_0_0) begin
      failures++;
      $display("FAIL async_reset got=%b exp=%b", got_vec(), 5'b000_0_0);
    end
    @(negedge i_clk);
    i_reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 3'd4, 1);
      checks++;
      if (got_vec() !== 5'b000_0_0) begin
        failures++;
        $display("FAIL async_idle cyc=%0d got=%b exp=%b", i, got_vec(), 5'b000_0_0);
      end
    end
  endtask

  task automatic test_k_change();
    do_reset();
    step(1, 0, 1, 3'd3, 1);
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 1, 3'($urandom_range(0, 7)), 1'($urandom));
      checks++;
      if (got_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL k_change cyc=%0d got=%b exp=%b", i, got_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
           1'($urandom));
      checks++;
      if (got_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL random cyc=%0d got=%b exp=%b", i, got_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_periodic();
    test_one_shot();
    test_en_toggle();
    test_stop();
    test_k_bounds();
    test_async_reset();
    test_k_change();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/counter_mod_k_down.md
Name: counter_mod_k_down

Overview:
Loadable modulo-k down-counter (timer) that consumes a tick enable and emits a one-cycle borrow pulse when it passes zero.
Counterpart to the up-counting modulo-k rollover counter: that block produces tick/rollover pulses, and this block counts them down to generate timeouts or divided periodic events.
It supports one-shot and periodic modes with a start/stop/busy control interface.
It sits between tick sources (prescalers, rollover outputs) and control FSMs that need "k events elapsed" notification.

Parameters:
N, 3, counter width in bits; k ranges 0..2^N-1.

Ports:
i_clk  input  1  system clock, rising-edge active.
i_reset  input  1  asynchronous, active-high reset.
i_k  input  N  modulus, sampled only when a start is accepted.
i_en  input  1  count tick; the counter decrements only in cycles where this is 1.
i_start  input  1  start request, level-sampled on the clock edge.
i_stop  input  1  abort request, level-sampled on the clock edge.
i_periodic  input  1  mode, sampled at start: 1 = reload after borrow, 0 = one-shot.
o_count  output  N  current count value.
o_borrow  output  1  registered one-cycle pulse on zero crossing.
o_busy  output  1  high while in RUN.

Behaviour:
- Reset (asynchronous, active-high): state IDLE, o_count=0, o_borrow=0, o_busy=0, k_q=0, periodic_q=0.
- All other updates happen on the rising edge of i_clk. Outputs are registered, with no combinational path from inputs.
- States: IDLE, RUN. o_busy = (state==RUN).
- IDLE:
  - i_start=1, i_stop=0, i_k!=0: k_q<=i_k, periodic_q<=i_periodic, o_count<=i_k-1, state<=RUN.
  - i_start with i_k==0 is ignored: stay IDLE, no borrow.
  - i_start and i_stop together: stop wins, stay IDLE.
  - o_borrow<=0 in every IDLE cycle.
  - i_en is ignored in IDLE.
- RUN, evaluated in priority order:
  1. i_stop=1: state<=IDLE, o_count<=0, o_borrow<=0. Stop takes priority over a simultaneous tick; a pending borrow is dropped.
  2. i_en=1 and o_count==0: o_borrow<=1.
     - If periodic_q=1: o_count<=k_q-1, stay RUN.
     - If periodic_q=0: o_count<=0, state<=IDLE.
  3. i_en=1 and o_count!=0: o_count<=o_count-1, o_borrow<=0.
  4. i_en=0: hold o_count, o_borrow<=0.
- i_start during RUN is ignored. i_k and i_periodic changes have no effect until the next accepted start.
- Latency: with i_en held at 1, o_borrow is high in the cycle following the k-th enabled edge after the start edge. Period is exactly k cycles, with no gap cycle at reload.
- k=1: o_count stays 0 and a borrow occurs on every enabled edge. In periodic mode with i_en=1, o_borrow stays high continuously.
- Width rules:
  - i_k-1 and k_q-1 are computed in N bits. k!=0 is guaranteed at load, so no underflow.
  - o_count never wraps through 2^N-1.
- Reset asserted mid-RUN: immediate return to reset values, independent of the clock.

Decomposition:
- Shared package counter_pkg:
  - typedef enum logic {ST_IDLE, ST_RUN} counter_state_t.
  - No other constants.
- Single module, no sub-module. The FSM and the datapath are small enough to live in one always_ff block plus output assigns.

Test Plan:
1. N=3, i_k=4, i_periodic=1, i_en=1, start pulse after reset release → o_count sequence 3,2,1,0,3,2,… with o_borrow=1 only in the cycles after count 0 (every 4 cycles); o_busy=1 throughout.
2. i_k=4, i_periodic=0, i_en=1 → counts 3,2,1,0, single o_borrow pulse, then o_busy=0 and o_count=0. A later i_start restarts the count from 3.
3. i_k=5, periodic, i_en toggling 1,0,1,0 → count decrements only on enabled edges; borrow after the 5th enabled edge (9 cycles); o_count holds during i_en=0.
4. i_stop asserted while o_count==0 and i_en=1 → no borrow pulse; IDLE and o_count=0 on the next cycle. i_start and i_stop together in IDLE → stays IDLE.
5. i_start with i_k=0 → remains IDLE, o_busy=0. i_k=1 periodic with i_en=1 → o_borrow high every cycle after the first edge. i_k=7 (max) → counts 6..0, borrow period 7.
6. Assert i_reset asynchronously mid-RUN (count=2), off a clock edge → o_count=0, o_busy=0, o_borrow=0 immediately. After deassert, the block is idle until the next start. Changing i_k during RUN does not alter the period.
